// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet receive-side unpacker.
//   STAT_W    : width of the saturating status counters
//   BCAST_MAC : broadcast destination address
//   state_t   : frame FSM encoding (IDLE / PASS / DROP)
//   sat_inc   : increment that sticks at all-ones
package eth_pkg;

  localparam int unsigned STAT_W    = 16;
  localparam logic [47:0] BCAST_MAC = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } state_t;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry register slice for a valid/ready stream.
// One cycle from input accept to m_valid; sustains one beat per clock while
// m_ready is high; output held stable while m_valid & !m_ready.
//   clk, rst          : clock, asynchronous active-high reset
//   s_data/valid/ready: upstream side (s_ready = not full)
//   m_data/valid/ready: downstream side
module axis_skid_buf #(
  parameter int unsigned DATA_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              push;
  logic              pop;

  assign s_ready = (count != 2'd2);
  assign m_valid = (count != 2'd0);
  assign m_data  = mem[rd_ptr];
  assign push    = s_valid & s_ready;
  assign pop     = m_valid & m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= s_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/eth_unpack.sv
// Receive-side frame unpacker: filters decoded Ethernet frames on destination
// MAC and EtherType, strips the header and forwards the payload bytes as an
// 8-bit stream with tlast/tuser, truncating at MAX_LEN bytes.
//   clk, rst                  : eth_clk, asynchronous active-high reset
//   s_eth_hdr_*               : header handshake and fields
//   s_eth_payload_axis_*      : payload byte stream in (tuser valid with tlast)
//   m_frame_axis_*            : payload byte stream out (tuser = bad/truncated)
//   m_last_src_mac            : source MAC of the last accepted frame
//   stat_good/drop/err_frames : saturating frame counters
module eth_unpack
  import eth_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC    = 48'h02_00_00_00_00_01,
  parameter logic [15:0] ETH_TYPE     = 16'h88B5,
  parameter bit          ACCEPT_BCAST = 1'b1,
  parameter int unsigned MAX_LEN      = 1500
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_eth_hdr_valid,
  output logic              s_eth_hdr_ready,
  input  logic [47:0]       s_eth_dest_mac,
  input  logic [47:0]       s_eth_src_mac,
  input  logic [15:0]       s_eth_type,
  input  logic [7:0]        s_eth_payload_axis_tdata,
  input  logic              s_eth_payload_axis_tvalid,
  output logic              s_eth_payload_axis_tready,
  input  logic              s_eth_payload_axis_tlast,
  input  logic              s_eth_payload_axis_tuser,
  output logic [7:0]        m_frame_axis_tdata,
  output logic              m_frame_axis_tvalid,
  input  logic              m_frame_axis_tready,
  output logic              m_frame_axis_tlast,
  output logic              m_frame_axis_tuser,
  output logic [47:0]       m_last_src_mac,
  output logic [STAT_W-1:0] stat_good_frames,
  output logic [STAT_W-1:0] stat_drop_frames,
  output logic [STAT_W-1:0] stat_err_frames
);

  localparam logic [15:0] LIMIT      = 16'(MAX_LEN);
  localparam logic [15:0] LIMIT_LAST = 16'(MAX_LEN - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] byte_cnt;
  logic        pass_hit;
  logic        hdr_fire;
  logic        beat;
  logic        at_limit;
  logic        over_limit;
  logic        fwd;
  logic        frame_end;
  logic        out_last;
  logic        out_user;
  logic        skid_ready;
  logic [9:0]  skid_out;

  assign pass_hit = (s_eth_type == ETH_TYPE) &&
                    ((s_eth_dest_mac == LOCAL_MAC) ||
                     (ACCEPT_BCAST && (s_eth_dest_mac == BCAST_MAC)));

  assign hdr_fire   = s_eth_hdr_valid & s_eth_hdr_ready;
  assign beat       = s_eth_payload_axis_tvalid & s_eth_payload_axis_tready;
  // byte_cnt stops at LIMIT, so over_limit marks a truncated frame
  assign over_limit = (byte_cnt >= LIMIT);
  assign at_limit   = (byte_cnt == LIMIT_LAST);
  assign fwd        = (state == PASS) && beat && !over_limit;
  assign frame_end  = beat && s_eth_payload_axis_tlast;

  // A frame of exactly MAX_LEN bytes ends normally; only a byte at the limit
  // without input tlast marks the frame as truncated.
  assign out_last = s_eth_payload_axis_tlast | at_limit;
  assign out_user = s_eth_payload_axis_tlast ? s_eth_payload_axis_tuser : at_limit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt                 = state;
    s_eth_hdr_ready           = 1'b0;
    s_eth_payload_axis_tready = 1'b0;
    case (state)
      IDLE: begin
        s_eth_hdr_ready = !rst;
        if (s_eth_hdr_valid && !rst) state_nxt = pass_hit ? PASS : DROP;
      end
      PASS: begin
        s_eth_payload_axis_tready = skid_ready;
        if (s_eth_payload_axis_tvalid && skid_ready && s_eth_payload_axis_tlast)
          state_nxt = IDLE;
      end
      DROP: begin
        s_eth_payload_axis_tready = 1'b1;
        if (s_eth_payload_axis_tvalid && s_eth_payload_axis_tlast)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt         <= '0;
      m_last_src_mac   <= '0;
      stat_good_frames <= '0;
      stat_drop_frames <= '0;
      stat_err_frames  <= '0;
    end else begin
      if (hdr_fire) begin
        byte_cnt <= '0;
        if (pass_hit) m_last_src_mac <= s_eth_src_mac;
      end else if (fwd) begin
        byte_cnt <= byte_cnt + 16'd1;
      end

      if (frame_end && (state == DROP))
        stat_drop_frames <= sat_inc(stat_drop_frames);

      if (frame_end && (state == PASS)) begin
        if (over_limit || s_eth_payload_axis_tuser)
          stat_err_frames <= sat_inc(stat_err_frames);
        else
          stat_good_frames <= sat_inc(stat_good_frames);
      end
    end
  end

  axis_skid_buf #(
    .DATA_W(10)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .s_data  ({out_user, out_last, s_eth_payload_axis_tdata}),
    .s_valid (fwd),
    .s_ready (skid_ready),
    .m_data  (skid_out),
    .m_valid (m_frame_axis_tvalid),
    .m_ready (m_frame_axis_tready)
  );

  assign m_frame_axis_tuser = skid_out[9];
  assign m_frame_axis_tlast = skid_out[8];
  assign m_frame_axis_tdata = skid_out[7:0];

endmodule

// File: doc/eth_unpack.md
Name: eth_unpack

Overview:
- Receive-side counterpart of the frame packer: accepts a decoded Ethernet frame (header fields plus payload AXI-Stream) on eth_clk.
- Filters the frame on destination MAC and EtherType, strips the header, and emits the payload as an 8-bit AXI-Stream with tlast/tuser toward the downstream consumer (DDR write path FIFO).
- Maintains per-frame length checking and saturating status counters.

Parameters:
- LOCAL_MAC, 48'h02_00_00_00_00_01, accepted unicast destination MAC
- ETH_TYPE, 16'h88B5, accepted EtherType
- ACCEPT_BCAST, 1, 1 = also accept dest MAC 48'hFFFF_FFFF_FFFF
- MAX_LEN, 1500, maximum payload bytes passed per frame; excess bytes are discarded

Ports:
- clk  input  1  eth_clk domain clock
- rst  input  1  asynchronous active-high reset
- s_eth_hdr_valid  input  1  header valid
- s_eth_hdr_ready  output  1  header ready
- s_eth_dest_mac  input  48  destination MAC
- s_eth_src_mac  input  48  source MAC
- s_eth_type  input  16  EtherType
- s_eth_payload_axis_tdata  input  8  payload byte
- s_eth_payload_axis_tvalid  input  1  payload valid
- s_eth_payload_axis_tready  output  1  payload ready
- s_eth_payload_axis_tlast  input  1  last payload byte
- s_eth_payload_axis_tuser  input  1  frame error flag, valid with tlast
- m_frame_axis_tdata  output  8  output byte
- m_frame_axis_tvalid  output  1  output valid
- m_frame_axis_tready  input  1  output ready
- m_frame_axis_tlast  output  1  last byte of accepted frame
- m_frame_axis_tuser  output  1  bad frame, valid with tlast
- m_last_src_mac  output  48  source MAC of most recently accepted frame
- stat_good_frames  output  16  accepted frames ending without error (saturating)
- stat_drop_frames  output  16  frames rejected by filter (saturating)
- stat_err_frames  output  16  accepted frames ending with tuser=1 or truncation (saturating)

Behaviour:
- Reset (async, active-high): FSM = IDLE; all outputs 0; counters 0; m_last_src_mac 0; skid buffer empty.
- FSM states:
  - IDLE: s_eth_hdr_ready=1, payload tready=0. On hdr_valid&ready, evaluate the filter: pass = (type==ETH_TYPE) && (dest==LOCAL_MAC || (ACCEPT_BCAST && dest==all-ones)). pass -> PASS, latch src into m_last_src_mac, clear byte count; fail -> DROP.
  - PASS: payload tready = skid buffer not full. Each accepted byte increments a 16-bit byte count.
    - While count < MAX_LEN: forward the byte.
    - Once count == MAX_LEN: the byte forwarded at count == MAX_LEN-1 is emitted with tlast=1, tuser=1 (truncated); remaining input is consumed without forwarding until input tlast.
    - Input tlast within the limit: forward with tlast=1 and tuser = s_tuser.
    - On input tlast -> IDLE.
  - DROP: payload tready=1; all bytes discarded; on tlast -> IDLE; stat_drop_frames++.
- Zero-length accepted frame cannot occur: the header is always followed by at least one payload byte with tlast.
- Output path: 2-entry skid buffer; 1-cycle latency input accept -> m_tvalid. Full throughput (1 byte/clk) when m_tready=1. m_* stable while tvalid & !tready.
- Counters: updated one cycle after the last byte is accepted on input.
  - good: tuser=0 and not truncated.
  - err: tuser=1 or truncated.
  - All counters saturate at 16'hFFFF.
- Header not accepted until the previous frame's input tlast is consumed; a new header may be accepted the cycle after tlast.
- Simultaneous count == MAX_LEN and input tlast: the byte is discarded, the frame counts as error, and tlast was already emitted on the MAX_LEN-th byte.
- Reset mid-frame: state, buffer and counters cleared immediately; upstream must restart at a header.

Decomposition:
- Shared package eth_pkg: BCAST_MAC constant; state encoding (IDLE, PASS, DROP); counter width constant STAT_W=16.
- One sub-module: axis_skid_buf (parameter DATA_W=10 carrying {tuser, tlast, tdata}), 2-entry register slice with valid/ready.

Test Plan:
- Header dest=LOCAL_MAC, type=16'h88B5, 64 bytes 0x00..0x3F, m_tready=1 -> 64 bytes out in order, tlast on 0x3F, tuser=0, stat_good=1, m_last_src_mac latched.
- Same frame with type=16'h0800 -> no output, tready=1 throughout, stat_drop=1.
- Dest=FFFF_FFFF_FFFF with ACCEPT_BCAST=1 -> passed; with ACCEPT_BCAST=0 -> dropped.
- MAX_LEN=16, 20-byte frame -> 16 bytes out, tlast+tuser on byte 16, remaining 4 consumed silently, stat_err=1.
- m_tready toggled 1/0 every cycle over a 32-byte frame -> no loss or duplication, data held stable while stalled; input s_tuser=1 on last -> m_tuser=1, stat_err incremented.
- rst asserted mid-frame at byte 10 -> all outputs 0 asynchronously; next good frame passes cleanly, stat_good=1.
